// File: rtl/aes_cbc_dec_chain_pkg.sv
// Shared block type and width for the CBC decrypt chaining stage.
package aes_cbc_dec_chain_pkg;
  localparam int AES_BLOCK_W = 128;
  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
endpackage

// File: rtl/aes_cbc_dec_chain_if.sv
// Ciphertext in, inv_aes request/response and plaintext out of the chaining stage.
interface aes_cbc_dec_chain_if;
  import aes_cbc_dec_chain_pkg::*;

  logic       iv_load_in;
  aes_block_t iv_in;
  logic       ecb_mode_in;
  logic       ct_valid_in;
  logic       ct_ready_out;
  aes_block_t ct_in;
  aes_block_t key_in;
  logic       dec_valid_out;
  aes_block_t dec_data_out;
  aes_block_t dec_key_out;
  logic       dec_valid_in;
  aes_block_t dec_data_in;
  logic       pt_valid_out;
  aes_block_t pt_out;
  logic       err_underflow_out;

  modport slave (
    input  iv_load_in, iv_in, ecb_mode_in, ct_valid_in, ct_in, key_in,
           dec_valid_in, dec_data_in,
    output ct_ready_out, dec_valid_out, dec_data_out, dec_key_out,
           pt_valid_out, pt_out, err_underflow_out
  );

  modport master (
    output iv_load_in, iv_in, ecb_mode_in, ct_valid_in, ct_in, key_in,
           dec_valid_in, dec_data_in,
    input  ct_ready_out, dec_valid_out, dec_data_out, dec_key_out,
           pt_valid_out, pt_out, err_underflow_out
  );
endinterface

// File: rtl/aes_cbc_dec_chain_fifo.sv
// Synchronous FIFO holding one chaining value per block in flight through inv_aes.
module aes_cbc_dec_chain_fifo #(
  parameter  int WIDTH = 128,
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_w, push_en, pop_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_w    = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign push_en   = push & ~full_w;
  assign pop_en    = pop & ~empty;
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_en) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: emptiness is tracked by the count alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/aes_cbc_dec_chain.sv
// CBC decrypt chaining around a fixed-latency inv_aes: forwards ciphertext,
// remembers the previous block per request and XORs it onto each result.
module aes_cbc_dec_chain
  import aes_cbc_dec_chain_pkg::*;
#(
  parameter  int INFLIGHT_DEPTH = 16,
  localparam int CNT_W = $clog2(INFLIGHT_DEPTH + 1)
) (
  input logic                clk,
  input logic                reset,
  aes_cbc_dec_chain_if.slave bus
);
  aes_block_t chain_q, chain_d;
  logic       dec_valid_q, dec_valid_d;
  aes_block_t dec_data_q, dec_data_d;
  aes_block_t dec_key_q, dec_key_d;
  logic       pt_valid_q, pt_valid_d;
  aes_block_t pt_q, pt_d;
  logic       err_q, err_d;

  logic       fire;
  aes_block_t push_val, head_val, fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic       fifo_empty;

  aes_cbc_dec_chain_fifo #(
    .WIDTH (AES_BLOCK_W),
    .DEPTH (INFLIGHT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fire),
    .push_data (push_val),
    .pop       (bus.dec_valid_in),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign bus.ct_ready_out = (fifo_count < CNT_W'(INFLIGHT_DEPTH));
  assign fire             = bus.ct_valid_in & bus.ct_ready_out;

  // A same-cycle IV load is the chaining value for the block being accepted.
  always_comb begin
    push_val = '0;
    if (!bus.ecb_mode_in) push_val = bus.iv_load_in ? bus.iv_in : chain_q;
    head_val = fifo_empty ? '0 : fifo_head;
  end

  always_comb begin
    chain_d     = chain_q;
    dec_valid_d = fire;
    dec_data_d  = dec_data_q;
    dec_key_d   = dec_key_q;
    pt_valid_d  = bus.dec_valid_in;
    pt_d        = pt_q;
    err_d       = err_q;
    if (fire) begin
      chain_d    = bus.ct_in;
      dec_data_d = bus.ct_in;
      dec_key_d  = bus.key_in;
    end else if (bus.iv_load_in) begin
      chain_d    = bus.iv_in;
    end
    if (bus.dec_valid_in) begin
      pt_d  = bus.dec_data_in ^ head_val;
      err_d = err_q | fifo_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q     <= '0;
      dec_valid_q <= 1'b0;
      dec_data_q  <= '0;
      dec_key_q   <= '0;
      pt_valid_q  <= 1'b0;
      pt_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      chain_q     <= chain_d;
      dec_valid_q <= dec_valid_d;
      dec_data_q  <= dec_data_d;
      dec_key_q   <= dec_key_d;
      pt_valid_q  <= pt_valid_d;
      pt_q        <= pt_d;
      err_q       <= err_d;
    end
  end

  assign bus.dec_valid_out     = dec_valid_q;
  assign bus.dec_data_out      = dec_data_q;
  assign bus.dec_key_out       = dec_key_q;
  assign bus.pt_valid_out      = pt_valid_q;
  assign bus.pt_out            = pt_q;
  assign bus.err_underflow_out = err_q;
endmodule

// File: tb/tb_aes_cbc_dec_chain.sv
// Bench for aes_cbc_dec_chain with a fixed-latency behavioural inv_aes downstream.
module tb_aes_cbc_dec_chain;
  import aes_cbc_dec_chain_pkg::*;

  localparam int DEPTH = 16;
  localparam int LAT   = 3;

  localparam aes_block_t K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam aes_block_t IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam aes_block_t CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam aes_block_t CT2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam aes_block_t CT3 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam aes_block_t PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam aes_block_t PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_cbc_dec_chain_if bus();

  aes_cbc_dec_chain #(.INFLIGHT_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input aes_block_t act, input aes_block_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // inv_aes stand-in: the known SP800-38A blocks decrypt to their published
  // values; anything else uses a cheap invertible toy transform.
  function automatic aes_block_t inv_model(input aes_block_t c, input aes_block_t k);
    if (k == K && c == CT1) return PT1 ^ IV;
    if (k == K && c == CT2) return PT2 ^ CT1;
    if (k == K && c == CT3) return PT1;
    return c ^ {k[63:0], k[127:64]};
  endfunction

  typedef struct {
    aes_block_t data;
    aes_block_t key;
    int         due;
  } job_t;

  job_t       jobs[$];
  aes_block_t sb[$];
  bit         hold    = 1'b0;
  bit         inj_req = 1'b0;
  aes_block_t inj_data = '0;
  int         cyc = 0;

  always @(negedge clk) begin
    job_t j;
    cyc++;
    if (reset) begin
      jobs.delete();
      bus.dec_valid_in = 1'b0;
      bus.dec_data_in  = '0;
    end else begin
      if (bus.dec_valid_out) jobs.push_back('{bus.dec_data_out, bus.dec_key_out, cyc + LAT});
      if (inj_req) begin
        bus.dec_valid_in = 1'b1;
        bus.dec_data_in  = inj_data;
        inj_req          = 1'b0;
      end else if (!hold && jobs.size() > 0 && jobs[0].due <= cyc) begin
        j = jobs.pop_front();
        bus.dec_valid_in = 1'b1;
        bus.dec_data_in  = inv_model(j.data, j.key);
      end else begin
        bus.dec_valid_in = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus.pt_valid_out) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pt: got %h expected no plaintext", bus.pt_out);
      end else begin
        check("pt", bus.pt_out, sb.pop_front());
      end
    end
  end

  // Called just after a negedge; returns one negedge after the block is accepted.
  task automatic send(input bit ld, input bit ecb, input aes_block_t ct,
                      input aes_block_t key, input aes_block_t exp);
    int tries = 0;
    bus.iv_load_in  = ld;
    bus.iv_in       = IV;
    bus.ecb_mode_in = ecb;
    bus.ct_in       = ct;
    bus.key_in      = key;
    bus.ct_valid_in = 1'b1;
    while (!bus.ct_ready_out && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got ready=0 for 200 cycles expected ready=1");
    end else begin
      sb.push_back(exp);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.ct_valid_in = 1'b0;
    bus.iv_load_in  = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int tries = 0;
    while ((sb.size() != 0 || jobs.size() != 0) && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: got %0d plaintexts outstanding expected 0", name, sb.size());
    end
  endtask

  typedef struct {
    bit         ld;
    bit         ecb;
    aes_block_t ct;
    aes_block_t exp;
  } vec_t;

  vec_t       tbl[5];
  aes_block_t tb_chain;
  aes_block_t ct_r;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, CT1, PT1};
    tbl[1] = '{1'b0, 1'b0, CT2, PT2};
    tbl[2] = '{1'b0, 1'b1, CT3, PT1};
    tbl[3] = '{1'b1, 1'b0, CT1, PT1};
    tbl[4] = '{1'b0, 1'b0, CT2, PT2};

    reset           = 1'b1;
    bus.iv_load_in  = 1'b0;
    bus.iv_in       = '0;
    bus.ecb_mode_in = 1'b0;
    bus.ct_valid_in = 1'b0;
    bus.ct_in       = '0;
    bus.key_in      = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    check1("rst_pt_valid", bus.pt_valid_out, 1'b0);
    check ("rst_pt", bus.pt_out, '0);
    check1("rst_dec_valid", bus.dec_valid_out, 1'b0);
    check1("rst_err", bus.err_underflow_out, 1'b0);
    check1("rst_ready", bus.ct_ready_out, 1'b1);

    // Standalone IV load, then back-to-back CBC, ECB and IV-with-block vectors.
    bus.iv_load_in = 1'b1;
    bus.iv_in      = IV;
    @(negedge clk);
    bus.iv_load_in = 1'b0;
    for (int i = 0; i < 5; i++) send(tbl[i].ld, tbl[i].ecb, tbl[i].ct, K, tbl[i].exp);
    idle();
    drain("table_drain");

    // Results held back so the in-flight FIFO fills with valid held high.
    @(posedge clk);
    #1 hold = 1'b1;
    @(negedge clk);
    fork
      begin
        repeat (25) @(posedge clk);
        #1 hold = 1'b0;
      end
    join_none
    tb_chain = IV;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (i < DEPTH) check1("stream_ready", bus.ct_ready_out, 1'b1);
      else if (i == DEPTH) check1("full_ready", bus.ct_ready_out, 1'b0);
      ct_r = {$urandom, $urandom, $urandom, $urandom};
      send(i == 0, 1'b0, ct_r, K, inv_model(ct_r, K) ^ tb_chain);
      tb_chain = ct_r;
    end
    idle();
    drain("stream_drain");

    check1("pre_uf_err", bus.err_underflow_out, 1'b0);
    @(posedge clk);
    #1 inj_data = 128'h0123456789abcdeffedcba9876543210;
    sb.push_back(inj_data);
    inj_req = 1'b1;
    repeat (2) @(negedge clk);
    check1("uf_pt_valid", bus.pt_valid_out, 1'b1);
    check1("uf_err", bus.err_underflow_out, 1'b1);
    send(1'b1, 1'b0, CT1, K, PT1);
    idle();
    drain("post_uf_drain");
    check1("uf_sticky", bus.err_underflow_out, 1'b1);

    // Reset with blocks in flight: nothing may emerge afterwards.
    @(posedge clk);
    #1 hold = 1'b1;
    @(negedge clk);
    send(1'b1, 1'b0, CT1, K, PT1);
    send(1'b0, 1'b0, CT2, K, PT2);
    send(1'b0, 1'b0, CT1, K, 128'h0);
    idle();
    @(posedge clk);
    #1 reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    check1("mid_rst_pt_valid", bus.pt_valid_out, 1'b0);
    check ("mid_rst_pt", bus.pt_out, '0);
    check1("mid_rst_dec_valid", bus.dec_valid_out, 1'b0);
    check ("mid_rst_dec_data", bus.dec_data_out, '0);
    check1("mid_rst_err", bus.err_underflow_out, 1'b0);
    check1("mid_rst_ready", bus.ct_ready_out, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check1("post_rst_quiet", bus.pt_valid_out, 1'b0);
    end

    bus.iv_load_in = 1'b1;
    bus.iv_in      = IV;
    @(negedge clk);
    bus.iv_load_in = 1'b0;
    send(1'b0, 1'b0, CT1, K, PT1);
    send(1'b0, 1'b0, CT2, K, PT2);
    idle();
    drain("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
